// File: rtl/arm_pkg.sv
// Shared encodings for the ARM execute stage: ALU commands, shift types,
// forwarding selects, NZCV bit positions and the multiplier FSM states.
package arm_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_MEM     = 2'd1;
  localparam logic [1:0] FWD_WB      = 2'd2;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/val2_generator.sv
// Second ALU operand: memory offset, rotated 8-bit immediate, or shifted Rm.
module val2_generator
  import arm_pkg::*;
(
  input  logic [31:0] op2src,
  input  logic [11:0] shifter_operand,
  input  logic        imm,
  input  logic        mem_op,
  output logic [31:0] val2
);

  logic [31:0] imm32;
  logic [4:0]  rot_amt;
  logic [4:0]  sh_amt;
  logic [63:0] imm_wide;
  logic [63:0] ror_wide;

  assign imm32    = {24'b0, shifter_operand[7:0]};
  assign rot_amt  = {shifter_operand[11:8], 1'b0};
  assign sh_amt   = shifter_operand[11:7];
  // Rotates are done by shifting a doubled copy right and keeping the low word.
  assign imm_wide = {imm32, imm32} >> rot_amt;
  assign ror_wide = {op2src, op2src} >> sh_amt;

  always_comb begin
    val2 = op2src;
    if (mem_op) begin
      val2 = {20'b0, shifter_operand};
    end else if (imm) begin
      val2 = imm_wide[31:0];
    end else begin
      case (shifter_operand[6:5])
        SHIFT_LSL: val2 = op2src << sh_amt;
        SHIFT_LSR: val2 = op2src >> sh_amt;
        SHIFT_ASR: val2 = $signed(op2src) >>> sh_amt;
        default:   val2 = ror_wide[31:0];
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding, Val2, ALU, NZCV register, branch target and a
// 32-iteration shift-add multiplier that freezes upstream through busy.
module exe_stage
  import arm_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [31:0] PC_in,
  input  logic [31:0] Val_Rn,
  input  logic [31:0] Val_Rm,
  input  logic [23:0] Signed_imm24,
  input  logic        Imm,
  input  logic [11:0] shifter_operand,
  input  logic [3:0]  ALU_CMD,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        S,
  input  logic [1:0]  fwd_sel1,
  input  logic [1:0]  fwd_sel2,
  input  logic [31:0] alu_res_mem,
  input  logic [31:0] wb_value,
  output logic [31:0] ALU_result,
  output logic [31:0] Val_Rm_fwd,
  output logic [31:0] Br_addr,
  output logic [3:0]  status_out,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(MUL_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_CYCLES - 1);

  mul_state_t       state, state_next;
  logic [CNT_W-1:0] counter;
  logic [31:0]      product, multiplicand, multiplier;
  logic [3:0]       status_reg;
  logic [31:0]      op1, op2src, val2;
  logic             mem_op, is_mul, start_mul;
  logic [3:0]       cmd;
  logic [32:0]      wide;
  logic [31:0]      alu_res;
  logic             c_new, v_new, flags_ok, status_we;

  assign mem_op = MEM_R_EN | MEM_W_EN;
  assign is_mul = !mem_op && (ALU_CMD == CMD_MUL);
  assign cmd    = mem_op ? CMD_ADD : ALU_CMD;

  // Select value 3 is unused and falls back to the register file.
  always_comb begin
    case (fwd_sel1)
      FWD_MEM: op1 = alu_res_mem;
      FWD_WB:  op1 = wb_value;
      default: op1 = Val_Rn;
    endcase
    case (fwd_sel2)
      FWD_MEM: op2src = alu_res_mem;
      FWD_WB:  op2src = wb_value;
      default: op2src = Val_Rm;
    endcase
  end

  val2_generator u_val2 (
    .op2src          (op2src),
    .shifter_operand (shifter_operand),
    .imm             (Imm),
    .mem_op          (mem_op),
    .val2            (val2)
  );

  // Multiplier FSM: the IDLE cycle that accepts a MUL already requests a freeze.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    start_mul  = 1'b0;
    case (state)
      MUL_IDLE: begin
        if (is_mul && !flush) begin
          busy       = 1'b1;
          start_mul  = 1'b1;
          state_next = MUL_RUN;
        end
      end
      MUL_RUN: begin
        if (flush) begin
          state_next = MUL_IDLE;
        end else begin
          busy = 1'b1;
          if (counter == LAST_ITER) state_next = MUL_DONE;
        end
      end
      default: state_next = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MUL_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter      <= '0;
      product      <= '0;
      multiplicand <= '0;
      multiplier   <= '0;
    end else if (start_mul) begin
      counter      <= '0;
      product      <= '0;
      multiplicand <= op1;
      multiplier   <= op2src;
    end else if (state == MUL_RUN && !flush) begin
      if (multiplier[0]) product <= product + multiplicand;
      multiplicand <= multiplicand << 1;
      multiplier   <= multiplier >> 1;
      counter      <= counter + 1'b1;
    end
  end

  always_comb begin
    alu_res  = '0;
    wide     = '0;
    c_new    = status_reg[FLAG_C];
    v_new    = status_reg[FLAG_V];
    flags_ok = 1'b1;
    case (cmd)
      CMD_MOV: alu_res = val2;
      CMD_MVN: alu_res = ~val2;
      CMD_ADD, CMD_ADC: begin
        wide    = {1'b0, op1} + {1'b0, val2} +
                  {32'b0, (cmd == CMD_ADC) & status_reg[FLAG_C]};
        alu_res = wide[31:0];
        c_new   = wide[32];
        v_new   = (op1[31] == val2[31]) && (alu_res[31] != op1[31]);
      end
      CMD_SUB, CMD_SBC: begin
        wide    = {1'b0, op1} - {1'b0, val2} -
                  {32'b0, (cmd == CMD_SBC) & ~status_reg[FLAG_C]};
        alu_res = wide[31:0];
        c_new   = ~wide[32];
        v_new   = (op1[31] != val2[31]) && (alu_res[31] != op1[31]);
      end
      CMD_AND: alu_res = op1 & val2;
      CMD_ORR: alu_res = op1 | val2;
      CMD_EOR: alu_res = op1 ^ val2;
      CMD_MUL: begin
        alu_res  = product;
        flags_ok = (state == MUL_DONE);
      end
      default: flags_ok = 1'b0;
    endcase
  end

  assign status_we = S && !mem_op && !busy && !flush && flags_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            status_reg <= '0;
    else if (status_we) status_reg <= {alu_res[31], (alu_res == 32'b0), c_new, v_new};
  end

  assign ALU_result = alu_res;
  assign Val_Rm_fwd = op2src;
  assign Br_addr    = PC_in + {{6{Signed_imm24[23]}}, Signed_imm24, 2'b00};
  assign status_out = status_reg;
  assign dbg_state  = state;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, flags, shifts, forwarding, branch
// target and the multiplier's busy/flush/reset behaviour.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] PC_in, Val_Rn, Val_Rm, alu_res_mem, wb_value;
  logic [23:0] Signed_imm24;
  logic        Imm, MEM_R_EN, MEM_W_EN, S;
  logic [11:0] shifter_operand;
  logic [3:0]  ALU_CMD;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [31:0] ALU_result, Val_Rm_fwd, Br_addr;
  logic [3:0]  status_out;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks_total  = 0;
  int checks_passed = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  exe_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .PC_in           (PC_in),
    .Val_Rn          (Val_Rn),
    .Val_Rm          (Val_Rm),
    .Signed_imm24    (Signed_imm24),
    .Imm             (Imm),
    .shifter_operand (shifter_operand),
    .ALU_CMD         (ALU_CMD),
    .MEM_R_EN        (MEM_R_EN),
    .MEM_W_EN        (MEM_W_EN),
    .S               (S),
    .fwd_sel1        (fwd_sel1),
    .fwd_sel2        (fwd_sel2),
    .alu_res_mem     (alu_res_mem),
    .wb_value        (wb_value),
    .ALU_result      (ALU_result),
    .Val_Rm_fwd      (Val_Rm_fwd),
    .Br_addr         (Br_addr),
    .status_out      (status_out),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic clear_inputs();
    flush = 0; PC_in = 0; Val_Rn = 0; Val_Rm = 0; alu_res_mem = 0; wb_value = 0;
    Signed_imm24 = 0; Imm = 0; MEM_R_EN = 0; MEM_W_EN = 0; S = 0;
    shifter_operand = 0; ALU_CMD = 0; fwd_sel1 = 0; fwd_sel2 = 0;
  endtask

  task automatic drive_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                          input logic imm, input logic [11:0] so, input logic s);
    @(negedge clk);
    clear_inputs();
    ALU_CMD = cmd; Val_Rn = rn; Val_Rm = rm; Imm = imm; shifter_operand = so; S = s;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    checks_total++;
    if (status_out !== 4'b0000) $display("FAIL reset_status actual=%b required=0000", status_out);
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b0 || dbg_state !== ST_IDLE)
      $display("FAIL reset_fsm actual busy=%b state=%0d required busy=0 state=0", busy, dbg_state);
    else checks_passed++;
    checks_total++;
    if (ALU_result !== 32'h0 || Br_addr !== 32'h0)
      $display("FAIL reset_outputs actual res=%h br=%h required 0/0", ALU_result, Br_addr);
    else checks_passed++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add_overflow();
    drive_op(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1);
    checks_total++;
    if (ALU_result !== 32'h8000_0000) $display("FAIL add_ovf_result actual=%h required=80000000", ALU_result);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (status_out !== 4'b1001) $display("FAIL add_ovf_flags actual=%b required=1001", status_out);
    else checks_passed++;
  endtask

  task automatic test_sub_flags();
    drive_op(4'b0100, 32'd5, 32'd5, 1'b0, 12'h000, 1'b1);
    checks_total++;
    if (ALU_result !== 32'h0) $display("FAIL sub_zero_result actual=%h required=0", ALU_result);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (status_out !== 4'b0110) $display("FAIL sub_zero_flags actual=%b required=0110", status_out);
    else checks_passed++;
    drive_op(4'b0100, 32'd5, 32'd3, 1'b0, 12'h000, 1'b0);
    checks_total++;
    if (ALU_result !== 32'd2) $display("FAIL sub_nos_result actual=%h required=2", ALU_result);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (status_out !== 4'b0110) $display("FAIL sub_nos_flags actual=%b required=0110", status_out);
    else checks_passed++;
  endtask

  task automatic test_alu_ops();
    // C = 1 here from the SUB test
    drive_op(4'b0011, 32'd1, 32'd2, 1'b0, 12'h000, 1'b0);
    checks_total++;
    if (ALU_result !== 32'd4) $display("FAIL adc_c1 actual=%h required=4", ALU_result);
    else checks_passed++;
    drive_op(4'b0101, 32'd10, 32'd3, 1'b0, 12'h000, 1'b0);
    checks_total++;
    if (ALU_result !== 32'd7) $display("FAIL sbc_c1 actual=%h required=7", ALU_result);
    else checks_passed++;
    drive_op(4'b0110, 32'hF0, 32'h3C, 1'b0, 12'h000, 1'b0);
    checks_total++;
    if (ALU_result !== 32'h30) $display("FAIL and actual=%h required=30", ALU_result);
    else checks_passed++;
    drive_op(4'b0111, 32'hF0, 32'h3C, 1'b0, 12'h000, 1'b0);
    checks_total++;
    if (ALU_result !== 32'hFC) $display("FAIL orr actual=%h required=fc", ALU_result);
    else checks_passed++;
    drive_op(4'b1000, 32'hF0, 32'h3C, 1'b0, 12'h000, 1'b0);
    checks_total++;
    if (ALU_result !== 32'hCC) $display("FAIL eor actual=%h required=cc", ALU_result);
    else checks_passed++;
    drive_op(4'b1001, 32'h0, 32'h0, 1'b1, 12'h000, 1'b0);
    checks_total++;
    if (ALU_result !== 32'hFFFF_FFFF) $display("FAIL mvn actual=%h required=ffffffff", ALU_result);
    else checks_passed++;
    drive_op(4'b1111, 32'd9, 32'd9, 1'b0, 12'h000, 1'b1);
    checks_total++;
    if (ALU_result !== 32'h0) $display("FAIL undef_result actual=%h required=0", ALU_result);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (status_out !== 4'b0110) $display("FAIL undef_flags actual=%b required=0110", status_out);
    else checks_passed++;
    drive_op(4'b0010, 32'hFFFF_FFFF, 32'd2, 1'b0, 12'h000, 1'b1);
    checks_total++;
    if (ALU_result !== 32'd1) $display("FAIL add_carry_result actual=%h required=1", ALU_result);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (status_out !== 4'b0010) $display("FAIL add_carry_flags actual=%b required=0010", status_out);
    else checks_passed++;
    drive_op(4'b0110, 32'hF0, 32'h0F, 1'b0, 12'h000, 1'b1);
    @(posedge clk); #1;
    checks_total++;
    if (status_out !== 4'b0110) $display("FAIL and_flags_keep_c actual=%b required=0110", status_out);
    else checks_passed++;
    drive_op(4'b0100, 32'd3, 32'd5, 1'b0, 12'h000, 1'b1);
    checks_total++;
    if (ALU_result !== 32'hFFFF_FFFE) $display("FAIL sub_borrow_result actual=%h required=fffffffe", ALU_result);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (status_out !== 4'b1000) $display("FAIL sub_borrow_flags actual=%b required=1000", status_out);
    else checks_passed++;
    drive_op(4'b0101, 32'd10, 32'd3, 1'b0, 12'h000, 1'b0);
    checks_total++;
    if (ALU_result !== 32'd6) $display("FAIL sbc_c0 actual=%h required=6", ALU_result);
    else checks_passed++;
  endtask

  task automatic test_shifts();
    drive_op(4'b0001, 32'h0, 32'h0, 1'b1, 12'h4FF, 1'b0);
    checks_total++;
    if (ALU_result !== 32'hFF00_0000) $display("FAIL imm_rot8 actual=%h required=ff000000", ALU_result);
    else checks_passed++;
    drive_op(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h240, 1'b0);
    checks_total++;
    if (ALU_result !== 32'hF800_0000) $display("FAIL asr4 actual=%h required=f8000000", ALU_result);
    else checks_passed++;
    drive_op(4'b0001, 32'h0, 32'h8000_0000, 1'b0, 12'h0A0, 1'b0);
    checks_total++;
    if (ALU_result !== 32'h4000_0000) $display("FAIL lsr1 actual=%h required=40000000", ALU_result);
    else checks_passed++;
    drive_op(4'b0001, 32'h0, 32'h0000_00F1, 1'b0, 12'h260, 1'b0);
    checks_total++;
    if (ALU_result !== 32'h1000_000F) $display("FAIL ror4 actual=%h required=1000000f", ALU_result);
    else checks_passed++;
    drive_op(4'b0001, 32'h0, 32'h0000_0003, 1'b0, 12'h200, 1'b0);
    checks_total++;
    if (ALU_result !== 32'h0000_0030) $display("FAIL lsl4 actual=%h required=30", ALU_result);
    else checks_passed++;
  endtask

  task automatic test_forwarding();
    drive_op(4'b0010, 32'd100, 32'd200, 1'b0, 12'h000, 1'b0);
    fwd_sel1 = 2'd1; alu_res_mem = 32'd10; fwd_sel2 = 2'd2; wb_value = 32'd3;
    #1;
    checks_total++;
    if (ALU_result !== 32'd13 || Val_Rm_fwd !== 32'd3)
      $display("FAIL fwd_mem_wb actual res=%0d rm=%0d required res=13 rm=3", ALU_result, Val_Rm_fwd);
    else checks_passed++;
    fwd_sel1 = 2'd3; fwd_sel2 = 2'd3;
    #1;
    checks_total++;
    if (ALU_result !== 32'd300 || Val_Rm_fwd !== 32'd200)
      $display("FAIL fwd_sel3 actual res=%0d rm=%0d required res=300 rm=200", ALU_result, Val_Rm_fwd);
    else checks_passed++;
    drive_op(4'b0110, 32'h1000, 32'hDEAD, 1'b0, 12'h004, 1'b1);
    MEM_W_EN = 1'b1;
    #1;
    checks_total++;
    if (ALU_result !== 32'h1004) $display("FAIL str_addr actual=%h required=1004", ALU_result);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (status_out !== 4'b1000) $display("FAIL str_flags actual=%b required=1000", status_out);
    else checks_passed++;
  endtask

  task automatic test_mul();
    int busy_cycles;
    drive_op(4'b0010, 32'h7FFF_FFFF, 32'h0, 1'b1, 12'h001, 1'b1);
    @(posedge clk); #1;
    drive_op(4'b1010, 32'd7, 32'd6, 1'b0, 12'h000, 1'b1);
    busy_cycles = 0;
    checks_total++;
    if (busy !== 1'b1 || dbg_state !== ST_IDLE)
      $display("FAIL mul_issue actual busy=%b state=%0d required busy=1 state=0", busy, dbg_state);
    else checks_passed++;
    if (busy === 1'b1) busy_cycles++;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      if (busy === 1'b1 && dbg_state === ST_RUN) busy_cycles++;
    end
    checks_total++;
    if (busy_cycles !== 33) $display("FAIL mul_busy_cycles actual=%0d required=33", busy_cycles);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (dbg_state !== ST_DONE || busy !== 1'b0 || ALU_result !== 32'd42)
      $display("FAIL mul_done actual state=%0d busy=%b res=%0d required state=2 busy=0 res=42",
               dbg_state, busy, ALU_result);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (dbg_state !== ST_IDLE) $display("FAIL mul_no_reissue actual=%0d required=0", dbg_state);
    else checks_passed++;
    checks_total++;
    if (status_out !== 4'b0001) $display("FAIL mul_flags actual=%b required=0001", status_out);
    else checks_passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_mul_flush();
    drive_op(4'b1010, 32'd3, 32'd4, 1'b0, 12'h000, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks_total++;
    if (busy !== 1'b0) $display("FAIL flush_busy actual=%b required=0", busy);
    else checks_passed++;
    @(posedge clk); #1;
    checks_total++;
    if (dbg_state !== ST_IDLE || status_out !== 4'b0001)
      $display("FAIL flush_state actual state=%0d flags=%b required state=0 flags=0001", dbg_state, status_out);
    else checks_passed++;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_mul_reset();
    drive_op(4'b1010, 32'd9, 32'd9, 1'b0, 12'h000, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks_total++;
    if (dbg_state !== ST_IDLE || status_out !== 4'b0000 || ALU_result !== 32'h0)
      $display("FAIL rst_mid_run actual state=%0d flags=%b res=%h required 0/0000/0",
               dbg_state, status_out, ALU_result);
    else checks_passed++;
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    #1;
    checks_total++;
    if (busy !== 1'b0) $display("FAIL rst_busy actual=%b required=0", busy);
    else checks_passed++;
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    PC_in = 32'h100; Signed_imm24 = 24'hFFFFFE;
    #1;
    checks_total++;
    if (Br_addr !== 32'hF8) $display("FAIL br_back actual=%h required=f8", Br_addr);
    else checks_passed++;
    PC_in = 32'h200; Signed_imm24 = 24'h000010;
    #1;
    checks_total++;
    if (Br_addr !== 32'h240) $display("FAIL br_fwd actual=%h required=240", Br_addr);
    else checks_passed++;
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_flags();
    test_alu_ops();
    test_shifts();
    test_forwarding();
    test_mul();
    test_mul_flush();
    test_mul_reset();
    test_branch();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage ARM pipeline.
- Consumes the decoded, registered instruction fields held in the ID/EX pipeline register. Produces the ALU result and the branch target for the EX/MEM register.
- Contains the Val2 generator, forwarding muxes, ALU, the architectural status register (NZCV) and an iterative 32-cycle multiplier.
- The multiplier stalls upstream stages through busy.

Parameters:
- MUL_CYCLES, 32, number of shift-add iterations for MUL (must equal data width).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  branch taken in this cycle; aborts an in-flight MUL
- PC_in  in  32  PC+4 of the instruction
- Val_Rn  in  32  register-file Rn value
- Val_Rm  in  32  register-file Rm value
- Signed_imm24  in  24  branch offset (words)
- Imm  in  1  I-bit
- shifter_operand  in  12  shifter operand field
- ALU_CMD  in  4  operation code
- MEM_R_EN, MEM_W_EN  in  1 each  load/store
- S  in  1  update flags
- fwd_sel1, fwd_sel2  in  2 each  0 = regfile, 1 = EX/MEM ALU result, 2 = WB value
- alu_res_mem  in  32  forwarded EX/MEM result
- wb_value  in  32  forwarded WB value
- ALU_result  out  32  result (address for LDR/STR)
- Val_Rm_fwd  out  32  forwarded Rm (store data)
- Br_addr  out  32  branch target
- status_out  out  4  {N,Z,C,V} status register
- busy  out  1  freeze request to IF/ID and ID/EX registers

Behaviour:
- Reset: FSM = IDLE, status_out = 0, counter = 0, product/multiplicand/multiplier regs = 0. Combinational outputs follow from these values with inputs at zero; busy = 0.
- Forwarding muxes select op1 (from Val_Rn) and op2src (from Val_Rm) per fwd_sel. A select value of 3 behaves as 0.
- Val2 generation (combinational):
  - MEM_R_EN or MEM_W_EN: Val2 = zero-extended shifter_operand[11:0].
  - else Imm = 1: Val2 = {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - else: shift op2src by so[11:7] using type so[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
- ALU command codes:
  - 0001 MOV = Val2
  - 1001 MVN = ~Val2
  - 0010 ADD
  - 0011 ADC (+C from status_out)
  - 0100 SUB/CMP
  - 0101 SBC = op1 - Val2 - ~C
  - 0110 AND/TST
  - 0111 ORR
  - 1000 EOR
  - 1010 MUL
  - other codes: result 0, no flag update.
- Memory ops force ADD regardless of ALU_CMD.
- Arithmetic is 33-bit wide.
  - ADD/ADC: C = bit 32; V = signed overflow.
  - SUB/SBC: C = NOT borrow; V = signed overflow.
  - Logic/MOV/MVN: C and V unchanged.
  - N = result[31]; Z = (result == 0).
- Br_addr = PC_in + ({{6{imm24[23]}}, imm24} << 2), combinational.
- Status register:
  - Written at posedge when S = 1, not a memory op, busy = 0 and flush = 0.
  - MUL writes N and Z only.
- MUL FSM, states IDLE, RUN, DONE:
  - IDLE with ALU_CMD = 1010 and no flush: busy = 1 combinationally. At the edge, latch op1 and op2 (Val2 is not used for MUL) and go to RUN; counter = 0, product = 0.
  - RUN: each cycle, if multiplier[0] then product += multiplicand; shift multiplicand left and multiplier right; counter++. After MUL_CYCLES iterations go to DONE. busy = 1 throughout.
  - DONE: busy = 0, ALU_result = product[31:0], flags per S. Go to IDLE unconditionally, so the same still-present MUL is not re-issued.
  - Latency: a MUL occupies the stage for 34 cycles (1 IDLE + 32 RUN + 1 DONE).
  - flush in RUN or DONE: go to IDLE, busy deasserts in the same cycle, no flag write.
  - rst at any time: immediate IDLE.
- Non-MUL ops are single-cycle, with busy = 0.

Decomposition:
- Shared package arm_pkg holds:
  - ALU_CMD encodings
  - shift-type codes
  - fwd_sel codes
  - NZCV bit indices
  - MUL FSM state enum
- One sub-module, val2_generator: combinational rotate/shift/offset selection.
- ALU and FSM stay in exe_stage.

Test Plan:
- ADD with S = 1, op1 = 0x7FFFFFFF, Imm = 1, so = 0x001 → ALU_result 0x80000000; next cycle status_out = 1001 (N = 1, V = 1).
- SUB with S = 1, Rn = 5, Rm = 5, LSL 0 → result 0; status Z = 1, C = 1. Same op with S = 0 → status unchanged.
- Imm rotate, so = 0x4FF (rotate right by 8) → Val2 = 0xFF000000. MOV with ASR #4 of 0x80000000 → 0xF8000000.
- Forwarding: fwd_sel1 = 1, alu_res_mem = 10, fwd_sel2 = 2, wb_value = 3, ADD with Imm = 0, so = 0 (LSL #0) → result 13. STR with offset 0x004 → address Rn + 4.
- MUL, Rn = 7, Rm = 6 (S = 1):
  - busy high for 33 cycles, then the DONE cycle shows ALU_result = 42 with busy = 0.
  - Upstream registers are held throughout.
  - No re-issue on the following cycle.
- MUL aborted by flush mid-RUN (cycle 10) → busy 0 the same cycle, FSM IDLE, status unchanged. rst mid-RUN → IDLE and all registers zero. B with imm24 = 0xFFFFFE, PC_in = 0x100 → Br_addr 0xF8.
